// File: rtl/exe_div_unit.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU) for the execute stage.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the BUSY iterations.
module exe_div_unit #(
    parameter int                 ALUOP_W = 8,
    parameter logic [ALUOP_W-1:0] OP_DIV  = 8'h16,
    parameter logic [ALUOP_W-1:0] OP_DIVU = 8'h17
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst_n,
    input  logic [ALUOP_W-1:0] exe_aluop,
    input  logic [31:0]        exe_src1,
    input  logic [31:0]        exe_src2,
    input  logic [3:0]         stall,
    input  logic               flush,
    output logic               stallreq_exe,
    output logic               div_ready,
    output logic [31:0]        div_hi,
    output logic [31:0]        div_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic STOP = 1'b1;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] divisor_q;
    logic [31:0] dividend_q;
    logic        s1_q;
    logic        s2_q;
    logic        signed_q;
    logic        div_ready_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_div_s;
    logic        start_s;
    logic [32:0] rem33_s;
    logic        ge_s;
    logic [31:0] rem_step_s;
    logic [31:0] quot_step_s;
    logic [31:0] fin_hi_s;
    logic [31:0] fin_lo_s;
    logic        stall_unused_s;

    assign stall_unused_s = ^stall[2:0];

    // Start decode, one restoring step, and sign/zero correction of the final step.
    always_comb begin
        is_div_s    = (exe_aluop == OP_DIV);
        start_s     = (is_div_s || (exe_aluop == OP_DIVU)) && !flush;
        rem33_s     = {rem_q, quot_q[31]};
        ge_s        = (rem33_s >= {1'b0, divisor_q});
        rem_step_s  = ge_s ? (rem33_s[31:0] - divisor_q) : rem33_s[31:0];
        quot_step_s = {quot_q[30:0], ge_s};
        if (divisor_q == 32'd0) begin
            fin_hi_s = dividend_q;
            fin_lo_s = 32'hFFFF_FFFF;
        end else if (signed_q) begin
            fin_hi_s = s1_q ? neg32(rem_step_s) : rem_step_s;
            fin_lo_s = (s1_q ^ s2_q) ? neg32(quot_step_s) : quot_step_s;
        end else begin
            fin_hi_s = rem_step_s;
            fin_lo_s = quot_step_s;
        end
    end

    // Stall request must rise in the start cycle itself, so it is decoded from state.
    always_comb begin
        stallreq_exe = 1'b0;
        if (!cpu_rst_n) begin
            stallreq_exe = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:  stallreq_exe = start_s;
                S_BUSY:  stallreq_exe = !flush;
                S_DONE:  stallreq_exe = 1'b0;
                default: stallreq_exe = 1'b0;
            endcase
        end
    end

    // Divider FSM, iteration datapath and registered results.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            rem_q       <= 32'd0;
            quot_q      <= 32'd0;
            divisor_q   <= 32'd0;
            dividend_q  <= 32'd0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            signed_q    <= 1'b0;
            div_ready_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            div_ready_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_s) begin
                        rem_q      <= 32'd0;
                        quot_q     <= abs32(exe_src1, is_div_s);
                        divisor_q  <= abs32(exe_src2, is_div_s);
                        dividend_q <= exe_src1;
                        s1_q       <= exe_src1[31];
                        s2_q       <= exe_src2[31];
                        signed_q   <= is_div_s;
                        cnt_q      <= 5'd0;
`ifdef DIV_ZERO_FAST_EN
                        if (exe_src2 == 32'd0) begin
                            state_q     <= S_DONE;
                            div_ready_q <= 1'b1;
                            hi_q        <= exe_src1;
                            lo_q        <= 32'hFFFF_FFFF;
                        end else begin
                            state_q <= S_BUSY;
                        end
`else
                        state_q <= S_BUSY;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    rem_q  <= rem_step_s;
                    quot_q <= quot_step_s;
                    if (cnt_q == 5'd31) begin
                        state_q     <= S_DONE;
                        cnt_q       <= 5'd0;
                        div_ready_q <= 1'b1;
                        hi_q        <= fin_hi_s;
                        lo_q        <= fin_lo_s;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                S_DONE: begin
                    // Results stay put while a later stage holds the pipeline.
                    if (stall[3] != STOP) begin
                        state_q     <= S_IDLE;
                        div_ready_q <= 1'b0;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= 5'd0;
                    div_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign div_ready = div_ready_q;
    assign div_hi    = hi_q;
    assign div_lo    = lo_q;

endmodule

// File: tb/tb_exe_div_unit.sv
// Directed self-checking bench for exe_div_unit (honours DIV_ZERO_FAST_EN if defined).
module tb_exe_div_unit;

    localparam logic [7:0] OP_DIV  = 8'h16;
    localparam logic [7:0] OP_DIVU = 8'h17;
    localparam logic [7:0] OP_NOP  = 8'h00;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  aluop;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  stall;
    logic        flush;
    logic        stallreq;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;

    exe_div_unit dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .exe_aluop   (aluop),
        .exe_src1    (src1),
        .exe_src2    (src2),
        .stall       (stall),
        .flush       (flush),
        .stallreq_exe(stallreq),
        .div_ready   (ready),
        .div_hi      (hi),
        .div_lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a divide at the next negedge; stallreq must rise in that same cycle.
    task automatic do_start(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input string tag);
        @(negedge clk);
        aluop = op;
        src1  = a;
        src2  = b;
        flush = 1'b0;
        #1;
        check_eq({tag, "_ready_at_T"}, {31'd0, ready}, 32'd0);
        check_eq({tag, "_stallreq_T"}, {31'd0, stallreq}, 32'd1);
    endtask

    // Count cycles with stallreq high (bounded), then check the results in DONE.
    task automatic wait_check(input int exp_lat, input logic [31:0] exp_lo,
                              input logic [31:0] exp_hi, input string tag);
        int lat;
        lat = 0;
        while (stallreq && lat < 100) begin
            lat++;
            @(negedge clk);
            #1;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check_eq({tag, "_lo"}, lo, exp_lo);
        check_eq({tag, "_hi"}, hi, exp_hi);
    endtask

    // Leave DONE with the pipeline advancing to a non-divide instruction.
    task automatic retire(input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string tag);
        stall = 4'b0000;
        aluop = OP_NOP;
        @(negedge clk);
        #1;
        check_eq({tag, "_ready_drop"}, {31'd0, ready}, 32'd0);
        check_eq({tag, "_idle_stallreq"}, {31'd0, stallreq}, 32'd0);
        check_eq({tag, "_hold_lo"}, lo, exp_lo);
        check_eq({tag, "_hold_hi"}, hi, exp_hi);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        aluop = OP_NOP;
        src1  = 32'd0;
        src2  = 32'd0;
        stall = 4'b0000;
        flush = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_stallreq", {31'd0, stallreq}, 32'd0);
        check_eq("rst_ready", {31'd0, ready}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        rst_n = 1'b1;

        // Non-divide op in IDLE: no stall request
        @(negedge clk);
        aluop = 8'h20;
        #1;
        check_eq("nop_stallreq", {31'd0, stallreq}, 32'd0);
        aluop = OP_NOP;

        do_start(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
        wait_check(33, 32'd14, 32'd2, "divu_100_7");
        retire(32'd14, 32'd2, "divu_100_7");

        // Back-to-back: second divide starts in the IDLE cycle right after DONE
        do_start(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        wait_check(33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        do_start(OP_DIV, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        wait_check(33, 32'hFFFF_FFFD, 32'd1, "div_7_m2");
        retire(32'hFFFF_FFFD, 32'd1, "div_7_m2");

        do_start(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        wait_check(33, 32'h8000_0000, 32'd0, "div_ovf");
        retire(32'h8000_0000, 32'd0, "div_ovf");

        do_start(OP_DIVU, 32'd5, 32'd0, "divu_5_0");
        wait_check(ZLAT, 32'hFFFF_FFFF, 32'd5, "divu_5_0");
        retire(32'hFFFF_FFFF, 32'd5, "divu_5_0");

        do_start(OP_DIV, 32'hFFFF_FFF0, 32'd0, "div_m16_0");
        wait_check(ZLAT, 32'hFFFF_FFFF, 32'hFFFF_FFF0, "div_m16_0");
        retire(32'hFFFF_FFFF, 32'hFFFF_FFF0, "div_m16_0");

        // Flush at BUSY cnt=10 (cycle T+11)
        do_start(OP_DIVU, 32'd100, 32'd7, "flush");
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        check_eq("flush_stallreq", {31'd0, stallreq}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        aluop = OP_NOP;
        #1;
        check_eq("flush_idle_stallreq", {31'd0, stallreq}, 32'd0);
        check_eq("flush_ready", {31'd0, ready}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("flush_ready_later", {31'd0, ready}, 32'd0);
        check_eq("flush_lo_kept", lo, 32'hFFFF_FFFF);
        do_start(OP_DIVU, 32'd9, 32'd3, "divu_9_3");
        wait_check(33, 32'd3, 32'd0, "divu_9_3");
        retire(32'd3, 32'd0, "divu_9_3");

        // Later stage stalls: DONE must hold and never restart
        stall = 4'b1000;
        do_start(OP_DIVU, 32'd1000, 32'd33, "hold");
        wait_check(33, 32'd30, 32'd10, "hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check_eq("hold_ready", {31'd0, ready}, 32'd1);
            check_eq("hold_stallreq", {31'd0, stallreq}, 32'd0);
            check_eq("hold_lo", lo, 32'd30);
            check_eq("hold_hi", hi, 32'd10);
        end
        retire(32'd30, 32'd10, "hold");

        // Asynchronous reset in the middle of BUSY
        do_start(OP_DIVU, 32'd100, 32'd7, "rst_busy");
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rstb_stallreq", {31'd0, stallreq}, 32'd0);
        check_eq("rstb_ready", {31'd0, ready}, 32'd0);
        check_eq("rstb_hi", hi, 32'd0);
        check_eq("rstb_lo", lo, 32'd0);
        @(negedge clk);
        aluop = OP_NOP;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rstb_after_ready", {31'd0, ready}, 32'd0);
        check_eq("rstb_after_stallreq", {31'd0, stallreq}, 32'd0);
        check_eq("rstb_after_lo", lo, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
